// File: rtl/priority_enc_pkg.sv
// Shared types and defaults for the sequential priority encoder.
package priority_enc_pkg;

   typedef enum logic {IDLE, EMIT} enc_state_t;

   localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/bit_index_finder.sv
// Combinational index picker over the pending vector; ENC_MSB_FIRST_EN selects the
// highest set bit instead of the lowest.
module bit_index_finder
   import priority_enc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] pend,
   output logic [IDX_W-1:0] idx,
   output logic             one_set
);

   // The last match in loop order wins, so the scan direction picks the priority end.
   always_comb begin
      // NOTE: default assignment first so every path drives idx and no latch is inferred.
      idx = '0;
`ifdef ENC_MSB_FIRST_EN
      for (int i = 0; i < WIDTH; i++) begin
         if (pend[i]) idx = IDX_W'(i);
      end
`else
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pend[i]) idx = IDX_W'(i);
      end
`endif
   end

   // Clearing the lowest set bit leaves zero only when exactly one bit was set.
   assign one_set = (pend != '0) && ((pend & (pend - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential WIDTH-to-index encoder: accepts a request vector and streams the index of
// every set bit, one per handshake. ENC_MSB_FIRST_EN (in bit_index_finder) flips the order.
module priority_encoder_seq
   import priority_enc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_none,
   output logic             busy
);

   enc_state_t       state;
   enc_state_t       state_next;
   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] idx_mask;
   logic [IDX_W-1:0] find_idx;
   logic             find_one;
   logic             pend_zero;
   logic             pend_last;
   logic             accept;
   logic             take;

   bit_index_finder #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_finder (
      .pend    (pend),
      .idx     (find_idx),
      .one_set (find_one)
   );

   assign pend_zero = (pend == '0);
   assign pend_last = pend_zero || find_one;
   assign idx_mask  = WIDTH'(1) << find_idx;
   assign accept    = in_valid && in_ready;
   assign take      = out_valid && out_ready;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EMIT;
         EMIT:    if (take && pend_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs are forced low during rst so nothing is offered or accepted.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_idx   = '0;
      out_last  = 1'b0;
      out_none  = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: in_ready = !rst;
         EMIT: begin
            out_valid = !rst;
            if (!rst) begin
               out_idx  = find_idx;
               out_none = pend_zero;
               out_last = pend_last;
            end
         end
         default: ;
      endcase
   end

   // Each consumed beat retires its bit; the final beat empties the register outright.
   always_ff @(posedge clk) begin
      // NOTE: pend is reset so a stale vector can never leak into the next burst.
      if (rst) begin
         pend <= '0;
      end else if (accept) begin
         pend <= in_vec;
      end else if (take) begin
         if (pend_last) pend <= '0;
         else           pend <= pend & ~idx_mask;
      end
   end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Self-checking bench: directed vector table, hand-written reset/hold sequences and a
// randomized run against a queue-based reference model.
module tb_priority_encoder_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_vec;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic       out_last;
   logic       out_none;
   logic       busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   priority_encoder_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_none  (out_none),
      .busy      (busy)
   );

   // seq holds beat indices in ascending order, one nibble per beat (beat 0 lowest).
   typedef struct {
      logic [7:0]  vec;
      bit          stall;
      int          n;
      logic [31:0] seq;
      bit          none;
   } vec_t;

   typedef struct packed {
      logic [2:0] idx;
      logic       last;
      logic       none;
   } beat_t;

   vec_t  tbl [7];
   beat_t model_q [$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the set bits of the vector in priority order, or one "none" beat.
   function automatic void push_beats(input logic [7:0] v);
      int order [$];
      for (int i = 0; i < 8; i++) if (v[i]) order.push_back(i);
`ifdef ENC_MSB_FIRST_EN
      order.reverse();
`endif
      if (order.size() == 0) begin
         model_q.push_back(beat_t'{idx: 3'd0, last: 1'b1, none: 1'b1});
      end else begin
         for (int k = 0; k < order.size(); k++)
            model_q.push_back(beat_t'{idx: 3'(order[k]), last: (k == order.size() - 1),
                                      none: 1'b0});
      end
   endfunction

   task automatic run_vec(input vec_t e);
      int k    = 0;
      int cyc  = 0;
      bit done = 0;
      int pos;
      @(negedge clk);
      in_valid = 1'b1; in_vec = e.vec; out_ready = 1'b0;
      #1;
      check_bit("tbl_accept_ready", in_ready, 1'b1);
      check_bit("tbl_idle_valid", out_valid, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; in_vec = ~e.vec;
      while (!done && cyc < 40) begin
         out_ready = e.stall ? cyc[0] : 1'b1;
         #1;
`ifdef ENC_MSB_FIRST_EN
         pos = e.n - 1 - k;
`else
         pos = k;
`endif
         check_bit("tbl_out_valid", out_valid, 1'b1);
         check_bit("tbl_in_ready_emit", in_ready, 1'b0);
         check("tbl_idx", 32'(out_idx), int'((e.seq >> (4 * pos)) & 32'hF));
         check_bit("tbl_last", out_last, k == e.n - 1);
         check_bit("tbl_none", out_none, e.none);
         if (out_ready) begin
            if (k == e.n - 1) done = 1;
            k++;
         end
         cyc++;
         @(negedge clk);
      end
      #1;
      check("tbl_beat_count", k, e.n);
      check_bit("tbl_ready_after", in_ready, 1'b1);
      check_bit("tbl_valid_after", out_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      logic exp_valid;
      logic exp_ready;
      beat_t exp_beat;

      rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      in_valid = 1'b1;
      #1;
      check_bit("rst_in_ready", in_ready, 1'b0);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check("rst_idx", 32'(out_idx), 0);
      check_bit("rst_last", out_last, 1'b0);
      check_bit("rst_none", out_none, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check_bit("post_rst_ready", in_ready, 1'b1);
      check_bit("post_rst_busy", busy, 1'b0);

      // Directed vectors
      tbl[0] = '{vec: 8'h24, stall: 0, n: 2, seq: 32'h0000_0052, none: 0};
      tbl[1] = '{vec: 8'h00, stall: 0, n: 1, seq: 32'h0000_0000, none: 1};
      tbl[2] = '{vec: 8'hFF, stall: 1, n: 8, seq: 32'h7654_3210, none: 0};
      tbl[3] = '{vec: 8'h80, stall: 0, n: 1, seq: 32'h0000_0007, none: 0};
      tbl[4] = '{vec: 8'h01, stall: 1, n: 1, seq: 32'h0000_0000, none: 0};
      tbl[5] = '{vec: 8'hA5, stall: 1, n: 4, seq: 32'h0000_7520, none: 0};
      tbl[6] = '{vec: 8'h18, stall: 0, n: 2, seq: 32'h0000_0043, none: 0};
      for (int t = 0; t < 7; t++) run_vec(tbl[t]);

      // in_valid held through EMIT: the second vector is taken once, only after IDLE.
      @(negedge clk);
      in_valid = 1'b1; in_vec = 8'h0C; out_ready = 1'b1;
      #1;
      check_bit("hold_accept", in_ready, 1'b1);
      @(negedge clk);
      in_vec = 8'h02;
      #1;
      check_bit("hold_ready0_a", in_ready, 1'b0);
`ifdef ENC_MSB_FIRST_EN
      check("hold_idx_a", 32'(out_idx), 3);
`else
      check("hold_idx_a", 32'(out_idx), 2);
`endif
      check_bit("hold_last_a", out_last, 1'b0);
      @(negedge clk);
      #1;
      check_bit("hold_ready0_b", in_ready, 1'b0);
`ifdef ENC_MSB_FIRST_EN
      check("hold_idx_b", 32'(out_idx), 2);
`else
      check("hold_idx_b", 32'(out_idx), 3);
`endif
      check_bit("hold_last_b", out_last, 1'b1);
      @(negedge clk);
      #1;
      check_bit("hold_bubble_valid", out_valid, 1'b0);
      check_bit("hold_bubble_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_bit("hold_second_valid", out_valid, 1'b1);
      check("hold_second_idx", 32'(out_idx), 1);
      check_bit("hold_second_last", out_last, 1'b1);
      check_bit("hold_second_none", out_none, 1'b0);
      @(negedge clk);
      #1;
      check_bit("hold_once_valid", out_valid, 1'b0);
      check_bit("hold_once_ready", in_ready, 1'b1);

      // rst mid-burst discards the remaining beat.
      @(negedge clk);
      in_valid = 1'b1; in_vec = 8'h81; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
`ifdef ENC_MSB_FIRST_EN
      check("rstmid_first_idx", 32'(out_idx), 7);
`else
      check("rstmid_first_idx", 32'(out_idx), 0);
`endif
      check_bit("rstmid_first_last", out_last, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_bit("rstmid_valid_in_rst", out_valid, 1'b0);
      check_bit("rstmid_ready_in_rst", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_bit("rstmid_valid_after", out_valid, 1'b0);
      check_bit("rstmid_busy_after", busy, 1'b0);
      check_bit("rstmid_ready_after", in_ready, 1'b1);
      @(negedge clk);
      #1;
      check_bit("rstmid_no_resume", out_valid, 1'b0);

      // Randomized run against the queue model; cycle 0 resets to align model and DUT.
      model_q.delete();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rst      = (c == 0) || ($urandom_range(0, 39) == 0);
         in_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0:       in_vec = 8'h00;
            1:       in_vec = 8'(1 << $urandom_range(0, 7));
            default: in_vec = 8'($urandom);
         endcase
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_valid = !rst && (model_q.size() != 0);
         exp_ready = !rst && (model_q.size() == 0);
         exp_beat  = exp_valid ? model_q[0] : beat_t'(0);
         check_bit("rnd_in_ready", in_ready, exp_ready);
         check_bit("rnd_out_valid", out_valid, exp_valid);
         check_bit("rnd_busy", busy, model_q.size() != 0);
         check("rnd_idx", 32'(out_idx), 32'(exp_beat.idx));
         check_bit("rnd_last", out_last, exp_beat.last);
         check_bit("rnd_none", out_none, exp_beat.none);
         if (rst)                          model_q.delete();
         else if (exp_ready && in_valid)   push_beats(in_vec);
         else if (exp_valid && out_ready)  void'(model_q.pop_front());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
